// File: rtl/poly_io_seq.sv
// Streaming load/unload sequencer for the poly unit coefficient RAM.
// Loads range-checked words into a bank, or unloads a bank through a 2-deep FIFO.
module poly_io_seq #(
  parameter int WID   = 12,
  parameter int LANES = 4,
  parameter int DEPTH = 32,
  parameter int NBANK = 2,
  parameter int Q     = 3329,
  localparam int W    = LANES * WID,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      mode,
  input  logic [BW-1:0]   bank,
  input  logic            run,
  output logic            busy,
  output logic            done,
  input  logic [W-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BW+AW-1:0] ram_addr,
  output logic            ram_we,
  output logic [W-1:0]    ram_wdata,
  input  logic [W-1:0]    ram_rdata,
  output logic            range_err,
  output logic            mode_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_UNLOAD,
    S_FIN
  } state_e;

  localparam logic [1:0]  M_DATAIN  = 2'd2;
  localparam logic [1:0]  M_DATAOUT = 2'd3;
  localparam logic [AW:0] LAST      = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] LIM       = (AW+1)'(DEPTH);
  localparam logic [WID:0] QV       = Q[WID:0];

  state_e             state_q;
  logic [BW-1:0]      bank_q;
  logic [AW:0]        wcnt_q;
  logic [AW:0]        rcnt_q;
  logic [AW:0]        ocnt_q;
  logic               busy_q;
  logic               done_q;
  logic               rerr_q;
  logic               merr_q;
  logic [BW+AW-1:0]   addr_q;
  logic [BW+AW-1:0]   addr_d;

  logic [W-1:0]       fifo_q [2];
  logic               rptr_q;
  logic               wptr_q;
  logic [1:0]         occ_q;
  logic               infl_q;

  logic               start;
  logic               ld_start;
  logic               ul_start;
  logic               accept;
  logic               pop;
  logic               issue_ul;
  logic               issue;
  logic               lane_bad;
  logic [2:0]         lvl;

  assign start    = (state_q == S_IDLE) && run;
  assign ld_start = start && (mode == M_DATAIN);
  assign ul_start = start && (mode == M_DATAOUT);
  assign accept   = (state_q == S_LOAD) && in_valid;
  assign pop      = out_valid && out_ready;

  // Credit the same-cycle pop so a steady stream issues one read per cycle.
  assign lvl      = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign issue_ul = (state_q == S_UNLOAD) &&
                    (rcnt_q < LIM) &&
                    (lvl < 3'd2);
  // The first read goes out with run so data appears two cycles later.
  assign issue    = ul_start || issue_ul;

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = (state_q == S_LOAD);
  assign ram_we    = accept;
  assign ram_wdata = accept ? in_data : '0;
  assign ram_addr  = addr_d;
  assign range_err = rerr_q;
  assign mode_err  = merr_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_data  = fifo_q[rptr_q];

  // Flag any lane of the incoming word that is not reduced mod Q.
  always_comb begin
    lane_bad = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ({1'b0, in_data[i*WID +: WID]} >= QV) begin
        lane_bad = 1'b1;
      end
    end
  end

  // RAM address: write or read target, otherwise hold the last one.
  always_comb begin
    addr_d = addr_q;
    if (accept) begin
      addr_d = {bank_q, wcnt_q[AW-1:0]};
    end else if (ul_start) begin
      addr_d = {bank, {AW{1'b0}}};
    end else if (issue_ul) begin
      addr_d = {bank_q, rcnt_q[AW-1:0]};
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      ocnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      merr_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      addr_q <= addr_d;
      done_q <= 1'b0;
      merr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          merr_q <= run && !mode[1];
          unique case (1'b1)
            ld_start: begin
              state_q <= S_LOAD;
              bank_q  <= bank;
              wcnt_q  <= '0;
              busy_q  <= 1'b1;
              rerr_q  <= 1'b0;
            end
            ul_start: begin
              state_q <= S_UNLOAD;
              bank_q  <= bank;
              rcnt_q  <= (AW+1)'(1);
              ocnt_q  <= '0;
              busy_q  <= 1'b1;
            end
            default: ;
          endcase
        end
        S_LOAD: begin
          if (accept) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (lane_bad) begin
              rerr_q <= 1'b1;
            end
            if (wcnt_q == LAST) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_UNLOAD: begin
          if (issue_ul) begin
            rcnt_q <= rcnt_q + 1'b1;
          end
          if (pop) begin
            ocnt_q <= ocnt_q + 1'b1;
            if (ocnt_q == LAST) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output FIFO: capture read data one cycle after issue, drain on handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rptr_q    <= 1'b0;
      wptr_q    <= 1'b0;
      occ_q     <= '0;
      infl_q    <= 1'b0;
    end else begin
      if (infl_q) begin
        fifo_q[wptr_q] <= ram_rdata;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      occ_q  <= occ_q + {1'b0, infl_q} - {1'b0, pop};
      infl_q <= issue;
    end
  end

endmodule

// File: tb/tb_poly_io_seq.sv
// Directed bench for poly_io_seq: table-driven loads/mode errors
// plus hand-written unload, back-pressure and reset sequences.
module tb_poly_io_seq;

  localparam int WID   = 12;
  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int NBANK = 2;
  localparam int QM    = 3329;
  localparam int W     = WID * LANES;
  localparam int AW    = 5;
  localparam int BW    = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      mode = '0;
  logic [BW-1:0]   bank = '0;
  logic            run = 1'b0;
  logic            busy;
  logic            done;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BW+AW-1:0] ram_addr;
  logic            ram_we;
  logic [W-1:0]    ram_wdata;
  logic [W-1:0]    ram_rdata;
  logic            range_err;
  logic            mode_err;

  poly_io_seq #(
    .WID(WID), .LANES(LANES), .DEPTH(DEPTH),
    .NBANK(NBANK), .Q(QM)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .bank(bank),
    .run(run), .busy(busy), .done(done),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .range_err(range_err), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [W-1:0] mem [NBANK*DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic [1:0] mode;
    logic       bank;
    int         base;
    int         bw0, bl0, bv0;
    int         bw1, bl1, bv1;
    int         brun;
    logic       exp_rerr;
    logic       exp_merr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] ld [DEPTH];
  logic         bad [DEPTH];
  logic [W-1:0] shadow [NBANK][DEPTH];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic build(input vec_t v);
    int lane;
    for (int k = 0; k < DEPTH; k++) begin
      bad[k] = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        lane = v.base + k;
        if (k == v.bw0 && i == v.bl0) lane = v.bv0;
        if (k == v.bw1 && i == v.bl1) lane = v.bv1;
        ld[k][i*WID +: WID] = 12'(lane);
        if (lane >= QM) bad[k] = 1'b1;
      end
    end
  endtask

  // Full load of ld[] into bank b, checked every cycle.
  task automatic do_load(input logic b, input int brun,
                         output logic rerr_end);
    logic seen;
    seen = 1'b0;
    run = 1'b1; mode = 2'd2; bank = b; in_valid = 1'b0;
    smp();
    chk("ld_busy_pre", busy, 0);
    step();
    run = 1'b0; mode = 2'd0; bank = ~b;
    for (int k = 0; k < DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = ld[k];
      run  = (k == brun);
      mode = (k == brun) ? 2'd3 : 2'd0;
      smp();
      chk("ld_busy", busy, 1);
      chk("ld_in_ready", in_ready, 1);
      chk("ld_we", ram_we, 1);
      chk("ld_addr", ram_addr, {b, 5'(k)});
      chk("ld_wdata", ram_wdata, ld[k]);
      chk("ld_rerr", range_err, seen);
      step();
      seen = seen | bad[k];
    end
    run = 1'b0;
    smp();
    chk("ld_done", done, 1);
    chk("ld_busy_fin", busy, 0);
    chk("ld_we_fin", ram_we, 0);
    chk("ld_ready_fin", in_ready, 0);
    chk("ld_rerr_fin", range_err, seen);
    step();
    in_valid = 1'b0;
    smp();
    chk("ld_done_low", done, 0);
    chk("ld_addr_hold", ram_addr, {b, 5'(DEPTH-1)});
    chk("ld_rerr_hold", range_err, seen);
    step();
    for (int k = 0; k < DEPTH; k++) shadow[b][k] = ld[k];
    rerr_end = range_err;
  endtask

  // Full unload of bank b with a 4-cycle out_ready pattern.
  task automatic do_unload(input logic b, input logic [3:0] pat,
                           output int first, output int bubbles);
    int t, n;
    logic stalled;
    logic [W-1:0] held;
    first = -1; bubbles = 0; n = 0; stalled = 1'b0; held = '0;
    run = 1'b1; mode = 2'd3; bank = b; out_ready = pat[0];
    smp();
    chk("ul_valid_pre", out_valid, 0);
    step();
    run = 1'b0; bank = ~b; t = 1;
    while (n < DEPTH && t < 400) begin
      out_ready = pat[t % 4];
      smp();
      chk("ul_busy", busy, 1);
      if (stalled) begin
        chk("ul_stall_valid", out_valid, 1);
        chk("ul_stall_data", out_data, held);
      end
      if (out_valid) begin
        if (first < 0) first = t;
        if (out_ready) begin
          chk("ul_data", out_data, shadow[b][n]);
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = out_data;
        end
      end else if (first >= 0) begin
        bubbles++;
      end
      step();
      t++;
    end
    chk("ul_count", 64'(n), 64'(DEPTH));
    out_ready = 1'b0;
    smp();
    chk("ul_done", done, 1);
    chk("ul_busy_fin", busy, 0);
    chk("ul_valid_fin", out_valid, 0);
    step();
    smp();
    chk("ul_done_low", done, 0);
    step();
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic re;
    int   f, bub;
    vec_t cl;

    vecs[0] = '{2'd2, 1'b1, 0,    -1,0,0,    -1,0,0,    -1, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 1'b0, 100,  5,2,3329,  9,0,4095,  -1, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 200,  7,1,3328,  -1,0,0,    -1, 1'b0, 1'b0};
    vecs[3] = '{2'd0, 1'b0, 0,    -1,0,0,    -1,0,0,    -1, 1'b0, 1'b1};
    vecs[4] = '{2'd1, 1'b1, 0,    -1,0,0,    -1,0,0,    -1, 1'b0, 1'b1};
    vecs[5] = '{2'd2, 1'b1, 3297, -1,0,0,    -1,0,0,    -1, 1'b0, 1'b0};
    vecs[6] = '{2'd2, 1'b0, 3298, -1,0,0,    -1,0,0,    -1, 1'b1, 1'b0};
    vecs[7] = '{2'd2, 1'b0, 50,   -1,0,0,    -1,0,0,    10, 1'b0, 1'b0};

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rerr", range_err, 0);
    chk("rst_merr", mode_err, 0);
    chk("rst_out_data", out_data, 0);
    step();
    rst = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].mode == 2'd2) begin
        build(vecs[v]);
        do_load(vecs[v].bank, vecs[v].brun, re);
        chk("tbl_rerr", re, vecs[v].exp_rerr);
      end else begin
        run = 1'b1; mode = vecs[v].mode; bank = vecs[v].bank;
        smp();
        chk("tbl_merr_pre", mode_err, 0);
        step();
        run = 1'b0;
        smp();
        chk("tbl_merr", mode_err, vecs[v].exp_merr);
        chk("tbl_merr_busy", busy, 0);
        chk("tbl_merr_ready", in_ready, 0);
        step();
        smp();
        chk("tbl_merr_pulse", mode_err, 0);
        chk("tbl_merr_busy2", busy, 0);
        step();
      end
    end

    // Unload bank 1 with out_ready held high
    do_unload(1'b1, 4'b1111, f, bub);
    chk("ul_first_latency", 64'(f), 64'd2);
    chk("ul_bubbles", 64'(bub), 64'd0);

    // Unload bank 0 with back-pressure 1,0,0,1
    do_unload(1'b0, 4'b1001, f, bub);

    // Reset in the middle of a load that has already flagged a range error
    cl = '{2'd2, 1'b0, 400, 3,1,3500, -1,0,0, -1, 1'b1, 1'b0};
    build(cl);
    run = 1'b1; mode = 2'd2; bank = 1'b0;
    step();
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data = ld[k];
      step();
    end
    in_data = ld[10];
    smp();
    chk("mid_rerr_pre", range_err, 1);
    chk("mid_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_in_ready", in_ready, 0);
    chk("mid_we", ram_we, 0);
    chk("mid_addr", ram_addr, 0);
    chk("mid_wdata", ram_wdata, 0);
    chk("mid_rerr", range_err, 0);
    chk("mid_done", done, 0);
    chk("mid_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    cl = '{2'd2, 1'b0, 600, -1,0,0, -1,0,0, -1, 1'b0, 1'b0};
    build(cl);
    do_load(1'b0, -1, re);
    chk("post_rst_rerr", re, 0);
    do_unload(1'b0, 4'b1111, f, bub);
    chk("post_rst_first", 64'(f), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/poly_io_seq.md
Name: poly_io_seq

Overview:
Parametrised streaming load/unload sequencer for the polynomial RAM of the poly unit. It implements the M_DATAIN and M_DATAOUT modes as a standalone block with valid/ready handshakes and multi-bank addressing. It adds coefficient range checking against Q and output back-pressure, so the NTT core only sees complete, validated polynomials. It sits between the external data interface and the poly unit's coefficient RAM.

Parameters:
WID, 12, coefficient width in bits
LANES, 4, coefficients packed per RAM word (word width W = LANES*WID)
DEPTH, 32, words per polynomial (power of 2); AW = log2(DEPTH)
NBANK, 2, polynomial banks in RAM (power of 2); BW = max(1, log2(NBANK))
Q, 3329, modulus for the range check

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
mode  in  2  0=M_NTT, 1=M_INTT, 2=M_DATAIN, 3=M_DATAOUT; sampled with run
bank  in  BW  target polynomial bank; sampled with run
run  in  1  start pulse
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
in_data  in  W  load word; lane i = bits [i*WID +: WID]
in_valid  in  1  load word valid
in_ready  out  1  load word accepted when in_valid && in_ready
out_data  out  W  unload word
out_valid  out  1  unload word valid
out_ready  in  1  consumer ready
ram_addr  out  BW+AW  {bank, word index}
ram_we  out  1  RAM write strobe
ram_wdata  out  W  RAM write data
ram_rdata  in  W  RAM read data; valid exactly 1 cycle after ram_addr
range_err  out  1  sticky: some loaded coefficient >= Q
mode_err  out  1  one-cycle pulse: run with mode 0/1

Behaviour:
- Reset (rst=0, async): state IDLE. busy, done, in_ready, out_valid, ram_we, range_err, mode_err = 0. ram_addr, out_data, and the counters = 0. Output buffer is empty and in-flight reads are discarded.
- FSM states: IDLE, LOAD, UNLOAD, FIN.
- IDLE, run=1:
  - mode=2 -> LOAD.
  - mode=3 -> UNLOAD.
  - mode 0/1 -> mode_err=1 next cycle and stay in IDLE.
  - On entry to LOAD or UNLOAD, latch bank, clear the word counter, and set busy=1 from the next cycle. In LOAD, also clear range_err.
- run while busy: ignored. mode and bank are not re-sampled.
- LOAD:
  - in_ready=1 for the whole state.
  - On each accept, in the same cycle (combinational): ram_we=1, ram_wdata=in_data, ram_addr={bank_q, wcnt}. wcnt then increments.
  - On the accept with wcnt=DEPTH-1, go to FIN. No further words are accepted.
  - Per accepted word, any lane >= Q sets range_err. The word is still written unchanged.
- UNLOAD:
  - Use a 2-entry output FIFO. Issue a read (ram_addr={bank_q, rcnt}, rcnt++) only when occupancy + in-flight reads < 2 and rcnt < DEPTH.
  - ram_rdata is captured into the FIFO the cycle after issue.
  - out_valid = FIFO non-empty; out_data = FIFO head.
  - Words leave in address order 0..DEPTH-1.
  - With out_ready held high, the first out_valid appears 2 cycles after run, then one word per cycle with no bubbles.
  - out_data is stable while out_valid=1 && out_ready=0.
  - When the word DEPTH-1 handshakes, go to FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. run in FIN is ignored.
- ram_we=0 outside LOAD accepts. ram_addr holds its last value when idle.
- Counters are AW+1 bits, so there is no wrap before the terminal compare. Bank bits never change mid-operation.
- range_err holds until the next LOAD start or reset.

Test Plan:
- Load, no gaps: reset, then run mode=2 bank=1, in_valid=1 with word k = {4{12'(k)}}. Expect 32 writes to addresses 32..63 on consecutive cycles, done pulse on the cycle after the last accept, busy=0, range_err=0.
- Unload, out_ready=1: after the load above, run mode=3 bank=1. Expect first out_valid 2 cycles after run, then 32 contiguous words matching the loaded data in order, then done.
- Unload with back-pressure: out_ready toggling 1,0,0,1 in a pattern. Expect no word lost or duplicated, out_data stable while stalled, FIFO never overflows, 32 words total, done after the last.
- Range check: load where word 5 lane 2 = 3329 and word 9 lane 0 = 4095. Expect range_err=1 from the cycle after word 5 is accepted and through done; a subsequent clean load clears it.
- Illegal mode and run-while-busy: run mode=0. Expect a single mode_err pulse and busy stays 0. During a load, pulse run mode=3. Expect it ignored and the load completes normally.
- Reset mid-operation: assert rst=0 after 10 loaded words. Expect all outputs 0 immediately (async). After release, a fresh load starts at word index 0.
